// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family: default width, count type and direction encoding.
package counter_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/updown_next_value.sv
// Combinational next-value stage: cur + 1 or cur - 1 (natural wrap at WIDTH bits).
module updown_next_value
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic [WIDTH-1:0] cur,
  input  dir_e             dir,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // An unknown direction falls to the default arm, so the value holds instead of going X
  always_comb begin
    nxt = cur;
    case (dir)
      DIR_UP:   nxt = cur + ONE;
      DIR_DOWN: nxt = cur - ONE;
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/four_bit_sync_counter.sv
// Free-running synchronous up/down counter with async active-high reset.
module four_bit_sync_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = CNT_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  updown_next_value #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur(count_q),
    .dir(dir_e'(up_down)),
    .nxt(count_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= RESET_VALUE;
    else     count_q <= count_d;
  end

  assign count = count_q;

  a_rst_hold: assert property (@(posedge clk) rst |-> count_q == RESET_VALUE);

  a_dir_known: assert property (@(posedge clk) !rst |-> !$isunknown(up_down));

  // Each unreset edge moves the count by exactly one step in the sampled direction
  a_step: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(up_down) |=>
      count_q == ($past(up_down) ? $past(count_q) + ONE : $past(count_q) - ONE));

endmodule

// File: tb/tb_four_bit_sync_counter.sv
// Directed bench for four_bit_sync_counter: reset, wrap in both directions, direction switch, async reset, random walk.
module tb_four_bit_sync_counter;

  logic       clk;
  logic       rst;
  logic       up_down;
  logic [3:0] count;

  int tests_run;
  int tests_failed;
  logic [3:0] model;

  four_bit_sync_counter dut (
    .clk(clk),
    .rst(rst),
    .up_down(up_down),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [3:0] expected);
    tests_run++;
    assert (count === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, count, expected);
    end
  endtask

  // Drop reset 2 ns ahead of the next rising edge
  task automatic release_before_edge();
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    up_down      = 1'b0;

    // Short reset pulse between edges clears the count with no clock edge
    #2 rst = 1'b1;
    #1 check_output("rst_async_pulse", 4'd0);
    #1 rst = 1'b0;
    tick();
    check_output("first_edge_after_pulse_down", 4'd15);

    // Reset held across three edges keeps the count at zero
    #2 rst = 1'b1;
    #1 check_output("rst_async_reassert", 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rst_hold", 4'd0);
    end

    // Down count from release, including 0 -> 15 wrap
    release_before_edge();
    model = 4'd0;
    for (int i = 0; i < 17; i++) begin
      tick();
      model = model - 4'd1;
      check_output("down_count", model);
    end
    check_output("down_wrap_end", 4'd15);

    // Up count: 15 -> 0, then a full lap 1..15, 0
    up_down = 1'b1;
    tick();
    check_output("up_wrap_from_15", 4'd0);
    model = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      model = model + 4'd1;
      check_output("up_count", model);
    end
    check_output("up_wrap_end", 4'd0);

    // Direction switch at 7 takes effect on the very next edge
    for (int i = 0; i < 7; i++) tick();
    check_output("reach_7", 4'd7);
    up_down = 1'b0;
    tick();
    check_output("switch_down_6", 4'd6);
    tick();
    check_output("switch_down_5", 4'd5);
    up_down = 1'b1;
    tick();
    check_output("switch_up_6", 4'd6);
    tick();
    check_output("switch_up_7", 4'd7);

    // Async reset at 9, then release with up_down = 1
    tick();
    tick();
    check_output("reach_9", 4'd9);
    #2 rst = 1'b1;
    #1 check_output("rst_async_mid_run", 4'd0);
    tick();
    check_output("rst_mid_run_hold", 4'd0);
    release_before_edge();
    tick();
    check_output("first_up_after_release", 4'd1);

    // Random walk against a mod-16 model
    model = 4'd1;
    for (int i = 0; i < 100; i++) begin
      up_down = 1'($urandom_range(0, 1));
      tick();
      model = up_down ? model + 4'd1 : model - 4'd1;
      check_output("random_walk", model);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
